// File: rtl/fwd_ctrl_unit_if.sv
// ID-stage / back-end handshake bundle for fwd_ctrl_unit.
// master: the pipeline side driving ID and back-end status.
// slave: the forwarding/interlock unit.
interface fwd_ctrl_unit_if;
  localparam int unsigned REG_W = 5;
  localparam int unsigned FWD_W = 3;
  localparam int unsigned CNT_W = 32;

  logic             id_valid;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_rs1_use;
  logic             id_rs2_use;
  logic [REG_W-1:0] id_rd;
  logic             id_we;
  logic             id_is_load;
  logic             pipe_adv;
  logic             flush;
  logic [FWD_W-1:0] fwd_ctrl1;
  logic [FWD_W-1:0] fwd_ctrl2;
  logic             id_stall;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_use, id_rs2_use,
           id_rd, id_we, id_is_load, pipe_adv, flush,
    input  fwd_ctrl1, fwd_ctrl2, id_stall, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_use, id_rs2_use,
           id_rd, id_we, id_is_load, pipe_adv, flush,
    output fwd_ctrl1, fwd_ctrl2, id_stall, stall_cnt
  );
endinterface

// File: rtl/fwd_ctrl_unit.sv
// Forwarding-select and load-use interlock for an EX->MM1->MM2->WB back end.
// Keeps a shadow scoreboard of the destinations in flight and resolves the
// ID-stage sources against it combinationally.
// Optional feature macro: FWD_PATH_EN
//   defined   : bypass selects EX/MM1/MM2_REG/MM2_MEM/WB, stall only on
//               a load still in EX or MM1.
//   undefined : no bypass, fwd_ctrl is always GR, any in-flight match stalls.
module fwd_ctrl_unit (
  input  logic           clk,
  input  logic           resetn,
  fwd_ctrl_unit_if.slave bus
);
  localparam int unsigned REG_W = 5;
  localparam int unsigned FWD_W = 3;
  localparam int unsigned CNT_W = 32;

  localparam logic [FWD_W-1:0] FWD_GR      = 3'd0;
  localparam logic [FWD_W-1:0] FWD_EX      = 3'd1;
  localparam logic [FWD_W-1:0] FWD_MM1     = 3'd2;
  localparam logic [FWD_W-1:0] FWD_MM2_REG = 3'd3;
  localparam logic [FWD_W-1:0] FWD_MM2_MEM = 3'd4;
  localparam logic [FWD_W-1:0] FWD_WB      = 3'd5;

  typedef struct packed {
    logic             valid;
    logic             we;
    logic             is_load;
    logic [REG_W-1:0] rd;
  } sb_entry_t;

  sb_entry_t        ex_q, mm1_q, mm2_q, wb_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic [3:0]       hit1_c, hit2_c;
  logic             stall_c;
  logic [FWD_W-1:0] fwd1_c, fwd2_c;
  logic             unused_load_bits;

  // An entry can supply a source only if it really writes a nonzero register that is read.
  function automatic logic entry_hit(sb_entry_t e, logic [REG_W-1:0] src, logic src_en);
    return e.valid & e.we & src_en & (e.rd == src) & (e.rd != '0);
  endfunction

`ifdef FWD_PATH_EN
  // Youngest match wins; MM2 splits on whether the data comes from memory.
  function automatic logic [FWD_W-1:0] pick_src(logic [3:0] hit, logic mm2_ld);
    if (hit[0])      return FWD_EX;
    else if (hit[1]) return FWD_MM1;
    else if (hit[2]) return mm2_ld ? FWD_MM2_MEM : FWD_MM2_REG;
    else if (hit[3]) return FWD_WB;
    else             return FWD_GR;
  endfunction
`endif

  // Hazard detection and forward-select, zero latency from scoreboard and ID.
  always_comb begin
    hit1_c  = '0;
    hit2_c  = '0;
    stall_c = 1'b0;
    fwd1_c  = FWD_GR;
    fwd2_c  = FWD_GR;

    hit1_c = {entry_hit(wb_q,  bus.id_rs1, bus.id_rs1_use),
              entry_hit(mm2_q, bus.id_rs1, bus.id_rs1_use),
              entry_hit(mm1_q, bus.id_rs1, bus.id_rs1_use),
              entry_hit(ex_q,  bus.id_rs1, bus.id_rs1_use)};
    hit2_c = {entry_hit(wb_q,  bus.id_rs2, bus.id_rs2_use),
              entry_hit(mm2_q, bus.id_rs2, bus.id_rs2_use),
              entry_hit(mm1_q, bus.id_rs2, bus.id_rs2_use),
              entry_hit(ex_q,  bus.id_rs2, bus.id_rs2_use)};

`ifdef FWD_PATH_EN
    // Load data is not available before MM2, so EX/MM1 load matches must wait.
    stall_c = bus.id_valid &
              ((hit1_c[0] & ex_q.is_load) | (hit1_c[1] & mm1_q.is_load) |
               (hit2_c[0] & ex_q.is_load) | (hit2_c[1] & mm1_q.is_load));
    fwd1_c  = pick_src(hit1_c, mm2_q.is_load);
    fwd2_c  = pick_src(hit2_c, mm2_q.is_load);
`else
    // Full interlock: wait until the producer has left WB.
    stall_c = bus.id_valid & ((|hit1_c) | (|hit2_c));
`endif
  end

  // WB never needs the load flag, and the interlock build ignores it everywhere.
  assign unused_load_bits = ^{ex_q.is_load, mm1_q.is_load, mm2_q.is_load, wb_q.is_load};

  // Scoreboard shift; flush squashes EX/MM1 and wins over the normal shift.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ex_q  <= '0;
      mm1_q <= '0;
      mm2_q <= '0;
      wb_q  <= '0;
    end else if (bus.flush) begin
      ex_q.valid  <= 1'b0;
      mm1_q.valid <= 1'b0;
      if (bus.pipe_adv) begin
        wb_q        <= mm2_q;
        mm2_q.valid <= 1'b0;
      end
    end else if (bus.pipe_adv) begin
      wb_q          <= mm2_q;
      mm2_q         <= mm1_q;
      mm1_q         <= ex_q;
      ex_q.valid    <= bus.id_valid & ~stall_c;
      ex_q.we       <= bus.id_we;
      ex_q.is_load  <= bus.id_is_load;
      ex_q.rd       <= bus.id_rd;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt_q <= '0;
    end else if (stall_c && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign bus.fwd_ctrl1 = fwd1_c;
  assign bus.fwd_ctrl2 = fwd2_c;
  assign bus.id_stall  = stall_c;
  assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_fwd_ctrl_unit.sv
// Self-checking bench for fwd_ctrl_unit: directed scenarios plus random
// traffic against a behavioural pipeline model.
module tb_fwd_ctrl_unit;
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  fwd_ctrl_unit_if bus();

  fwd_ctrl_unit dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Model: index 0=EX, 1=MM1, 2=MM2, 3=WB.
  bit          m_valid [4];
  bit          m_we    [4];
  bit          m_ld    [4];
  logic [4:0]  m_rd    [4];
  logic [31:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    for (int s = 0; s < 4; s++) begin
      m_valid[s] = 1'b0; m_we[s] = 1'b0; m_ld[s] = 1'b0; m_rd[s] = 5'd0;
    end
    m_cnt = 32'd0;
  endfunction

  function automatic bit m_hit(input int s, input logic [4:0] src, input logic en);
    return m_valid[s] && m_we[s] && en && (m_rd[s] == src) && (src != 5'd0);
  endfunction

  // Expected select code and hazard contribution for one source.
  function automatic void m_eval(input logic [4:0] src, input logic en,
                                 output logic [2:0] code, output bit haz);
`ifdef FWD_PATH_EN
    bit found;
    found = 1'b0;
`endif
    code = 3'd0;
    haz  = 1'b0;
    for (int s = 0; s < 4; s++) begin
      if (m_hit(s, src, en)) begin
`ifdef FWD_PATH_EN
        if (s < 2 && m_ld[s]) haz = 1'b1;
        if (!found) code = (s == 3) ? 3'd5 : (s == 2) ? (m_ld[s] ? 3'd4 : 3'd3) : 3'(s + 1);
        found = 1'b1;
`else
        haz = 1'b1;
`endif
      end
    end
  endfunction

  function automatic bit m_stall();
    logic [2:0] c;
    bit h1, h2;
    m_eval(bus.id_rs1, bus.id_rs1_use, c, h1);
    m_eval(bus.id_rs2, bus.id_rs2_use, c, h2);
    return bus.id_valid && (h1 || h2);
  endfunction

  // Advance the model across one clock edge using the inputs held there.
  function automatic void m_update();
    bit st;
    st = m_stall();
    if (st && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    if (bus.flush) begin
      if (bus.pipe_adv) begin
        m_valid[3] = m_valid[2]; m_we[3] = m_we[2]; m_ld[3] = m_ld[2]; m_rd[3] = m_rd[2];
        m_valid[2] = 1'b0;
      end
      m_valid[0] = 1'b0;
      m_valid[1] = 1'b0;
    end else if (bus.pipe_adv) begin
      for (int s = 3; s > 0; s--) begin
        m_valid[s] = m_valid[s-1]; m_we[s] = m_we[s-1]; m_ld[s] = m_ld[s-1]; m_rd[s] = m_rd[s-1];
      end
      m_valid[0] = bus.id_valid && !st;
      m_we[0]    = bus.id_we;
      m_ld[0]    = bus.id_is_load;
      m_rd[0]    = bus.id_rd;
    end
  endfunction

  task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic we, input logic ld, input logic adv, input logic fl);
    bus.id_valid = v;  bus.id_rs1 = rs1; bus.id_rs1_use = u1;
    bus.id_rs2 = rs2;  bus.id_rs2_use = u2;
    bus.id_rd = rd;    bus.id_we = we;   bus.id_is_load = ld;
    bus.pipe_adv = adv; bus.flush = fl;
  endtask

  // Compare combinational outputs against the model.
  task automatic check_model(input string tag);
    logic [2:0] c1, c2;
    bit h1, h2;
    #1;
    m_eval(bus.id_rs1, bus.id_rs1_use, c1, h1);
    m_eval(bus.id_rs2, bus.id_rs2_use, c2, h2);
    chk({tag, ".stall"}, 32'(bus.id_stall), 32'(bus.id_valid && (h1 || h2)));
    chk({tag, ".fwd1"}, 32'(bus.fwd_ctrl1), 32'(c1));
    chk({tag, ".fwd2"}, 32'(bus.fwd_ctrl2), 32'(c2));
  endtask

  task automatic tick();
    @(posedge clk);
    m_update();
    @(negedge clk);
    chk("stall_cnt", bus.stall_cnt, m_cnt);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #1;
    m_reset();
    chk("rst.cnt", bus.stall_cnt, 32'd0);
    chk("rst.stall", 32'(bus.id_stall), 32'd0);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    m_reset();
    repeat (2) @(negedge clk);
    chk("reset.stall", 32'(bus.id_stall), 32'd0);
    chk("reset.fwd1", 32'(bus.fwd_ctrl1), 32'd0);
    chk("reset.fwd2", 32'(bus.fwd_ctrl2), 32'd0);
    chk("reset.cnt", bus.stall_cnt, 32'd0);
    resetn = 1'b1;

`ifdef FWD_PATH_EN
    // ADD r5 then SUB reading r5 -> EX bypass
    do_reset();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0); check_model("add_r5"); tick();
    drive(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0); check_model("sub_r5");
    chk("ex_fwd", 32'(bus.fwd_ctrl1), 32'd1);
    chk("ex_nostall", 32'(bus.id_stall), 32'd0);
    tick();

    // LD r7 then ADD reading r7 -> 2 stalls then MM2_MEM
    do_reset();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0); check_model("ld_r7"); tick();
    drive(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      check_model("lduse");
      chk("lduse.stall", 32'(bus.id_stall), 32'd1);
      tick();
    end
    check_model("lduse_go");
    chk("lduse.mm2mem", 32'(bus.fwd_ctrl2), 32'd4);
    chk("lduse.cnt", bus.stall_cnt, 32'd2);
    tick();

    // r3 in EX and WB -> EX wins; r0 never forwards
    do_reset();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0); tick();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0); tick(); tick();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0); tick();
    drive(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0); check_model("r3");
    chk("r3.exwins", 32'(bus.fwd_ctrl1), 32'd1);
    tick();
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0); check_model("r0");
    chk("r0.gr", 32'(bus.fwd_ctrl1), 32'd0);
    tick();

    // LD r9 in EX flushed -> no hazard
    do_reset();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0); tick();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1); tick();
    drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0); check_model("flush");
    chk("flush.stall", 32'(bus.id_stall), 32'd0);
    chk("flush.fwd", 32'(bus.fwd_ctrl1), 32'd0);
    tick();

    // MM1 ALU r4 held by pipe_adv=0
    do_reset();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0); tick();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    drive(1'b1, 5'd4, 1'b1, 5'd4, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check_model("hold");
      chk("hold.mm1", 32'(bus.fwd_ctrl1), 32'd2);
      tick();
    end
`else
    // ADD r5 then read r5 -> interlock for 4 cycles
    do_reset();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0); check_model("add_r5"); tick();
    drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check_model("il");
      chk("il.stall", 32'(bus.id_stall), 32'd1);
      chk("il.gr", 32'(bus.fwd_ctrl1), 32'd0);
      tick();
    end
    check_model("il_go");
    chk("il.released", 32'(bus.id_stall), 32'd0);
    chk("il.cnt", bus.stall_cnt, 32'd4);
    tick();

    // Reset pulse in the middle of a stall
    do_reset();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0); tick();
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0);
    check_model("pre_rst");
    chk("pre_rst.stall", 32'(bus.id_stall), 32'd1);
    tick();
    chk("pre_rst.cnt", bus.stall_cnt, 32'd1);
    do_reset();
    check_model("post_rst");
    chk("post_rst.stall", 32'(bus.id_stall), 32'd0);
    tick();
`endif

    // Random traffic over a small register set to provoke hazards
    do_reset();
    for (int n = 0; n < 500; n++) begin
      logic fl;
      fl = ($urandom_range(0, 11) == 0);
      drive(fl ? 1'b0 : 1'($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 4) != 0),
            1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 3) != 0), fl);
      check_model("rand");
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fwd_ctrl_unit.md
FWD_CTRL_UNIT -- requirements
Module: fwd_ctrl_unit

Interface
REQ-001 SHALL use one clock and an asynchronous active-low reset: clk (input, 1, rising-edge clock), resetn (input, 1, asynchronous reset, active low).
REQ-002 SHALL provide id_valid (input, 1): the ID stage holds a valid instruction.
REQ-003 SHALL provide id_rs1 and id_rs2 (input, 5 each): source register numbers.
REQ-004 SHALL provide id_rs1_use and id_rs2_use (input, 1 each): the corresponding source is actually read.
REQ-005 SHALL provide id_rd (input, 5), id_we (input, 1) and id_is_load (input, 1): destination, write enable and load flag of the ID instruction.
REQ-006 SHALL provide pipe_adv (input, 1): the back end (EX->MM1->MM2->WB) advances this cycle.
REQ-007 SHALL provide flush (input, 1): cancel the instructions in EX and MM1.
REQ-008 SHALL provide fwd_ctrl1 and fwd_ctrl2 (output, 3 each): forward-source select for rs1 and rs2.
REQ-009 SHALL provide id_stall (output, 1): the ID instruction must not issue this cycle.
REQ-010 SHALL provide stall_cnt (output, 32): count of stalled cycles.
REQ-011 SHALL use fixed fwd_ctrl encodings: GR=0, EX=1, MM1=2, MM2_REG=3, MM2_MEM=4, WB=5.

Function
REQ-012 SHALL hold a shadow scoreboard of four entries (EX, MM1, MM2, WB); each entry stores valid, rd, we and is_load.
REQ-013 On a clock edge with pipe_adv=1, SHALL shift the scoreboard: WB<=MM2, MM2<=MM1, MM1<=EX, EX<={id_valid & ~id_stall, id_rd, id_we, id_is_load}.
REQ-014 On a clock edge with pipe_adv=0, SHALL hold every entry unchanged.
REQ-015 On flush=1, SHALL clear the EX and MM1 valid bits at the edge; if pipe_adv=1 in the same cycle, MM2 SHALL load invalid and WB SHALL take the old MM2; flush SHALL take priority over the shift.
REQ-016 An entry SHALL match a source only when: entry valid, entry we=1, entry rd equal to the source, rd!=0, and the source use bit is set.
REQ-017 fwd_ctrl for a source SHALL select the youngest matching entry in priority order EX > MM1 > MM2 > WB.
REQ-018 A matching EX or MM1 entry with is_load=1 SHALL assert id_stall, and its fwd_ctrl value is then don't-care.
REQ-019 A matching MM2 entry SHALL select MM2_MEM if it is a load, else MM2_REG.
REQ-020 A matching EX or MM1 entry that is not a load SHALL select EX or MM1 respectively.
REQ-021 With no match, fwd_ctrl SHALL be GR.
REQ-022 id_stall and fwd_ctrl SHALL be combinational from the current scoreboard and ID inputs (zero latency).
REQ-023 id_stall SHALL be forced to 0 when id_valid=0.
REQ-024 stall_cnt SHALL increment by 1 on each edge where id_stall=1 and SHALL saturate at 0xFFFFFFFF (no wrap).
REQ-025 The same register used as both rs1 and rs2 SHALL produce identical fwd_ctrl1 and fwd_ctrl2.

Reset
REQ-026 On resetn=0, SHALL immediately clear all scoreboard valid bits and set stall_cnt=0, so that fwd_ctrl1=fwd_ctrl2=GR and id_stall=0.
REQ-027 Reset asserted mid-stall SHALL discard all in-flight entries; after deassertion no stale hazard SHALL remain.

Configuration
REQ-028 The feature SHALL be controlled by macro FWD_PATH_EN.
REQ-029 With FWD_PATH_EN defined, SHALL behave per REQ-017 to REQ-021.
REQ-030 Without FWD_PATH_EN, fwd_ctrl1 and fwd_ctrl2 SHALL be constant GR, and any match in EX, MM1, MM2 or WB SHALL assert id_stall (full interlock).

Verification
REQ-031 Reset, then ADD r5 followed by SUB reading r5, pipe_adv=1 -> fwd_ctrl1=1 (EX), id_stall=0.
REQ-032 LD r7, then ADD reading r7 -> id_stall=1 for 2 cycles, then fwd_ctrl=4 (MM2_MEM); stall_cnt=2.
REQ-033 Writes to r3 in EX (ALU) and in WB, ID reads r3 -> fwd_ctrl=1 (EX wins); writes to r0 in any stage -> fwd_ctrl=0.
REQ-034 LD r9 in EX with flush=1 and pipe_adv=1, then ID reads r9 -> id_stall=0, fwd_ctrl=0.
REQ-035 pipe_adv=0 for 3 cycles with MM1 ALU write to r4 -> fwd_ctrl=2 held steady for all 3 cycles.
REQ-036 Without FWD_PATH_EN: ADD r5 then read r5 -> id_stall=1 for 4 cycles, fwd_ctrl=0 throughout; resetn pulse mid-stall -> id_stall=0 immediately, stall_cnt=0.
